// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU control codes, immediate formats,
// and the decoded-instruction bundle carried through the decode buffer.
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH
   } imm_fmt_t;

   typedef struct packed {
      logic [3:0]  alu_ctrl;
      logic        alu_src;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } dec_t;

   localparam int DEC_W = $bits(dec_t);

   typedef struct packed {
      logic [31:0] pc;
      dec_t        dec;
   } entry_t;

   // alt selects sub/sra on the funct3 slots that have a second meaning
   function automatic logic [3:0] alu_op_f3(input logic [2:0] f3, input logic alt);
      logic [3:0] r;
      case (f3)
         3'b000:  r = alt ? ALU_SUB : ALU_ADD;
         3'b001:  r = ALU_SLL;
         3'b010:  r = ALU_SLT;
         3'b011:  r = ALU_SLTU;
         3'b100:  r = ALU_XOR;
         3'b101:  r = alt ? ALU_SRA : ALU_SRL;
         3'b110:  r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder: one instruction word to a packed dec_t bundle.
// Illegal encodings clear every control flag and the ALU code.
module rv32i_decoder
   import rv32i_pkg::*;
(
   input  logic [31:0]      i_instr,
   output logic [DEC_W-1:0] o_dec
);

   logic [6:0] w_opcode;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   imm_fmt_t   w_fmt;
   dec_t       w_dec;

   assign w_opcode = i_instr[6:0];
   assign w_f3     = i_instr[14:12];
   assign w_f7     = i_instr[31:25];
   assign o_dec    = w_dec;

   always_comb begin
      w_dec        = '0;
      w_fmt        = IMM_NONE;
      w_dec.rs1    = i_instr[19:15];
      w_dec.rs2    = i_instr[24:20];
      w_dec.rd     = i_instr[11:7];
      w_dec.funct3 = w_f3;
      case (w_opcode)
         OP_R: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_ctrl  = alu_op_f3(w_f3, w_f7[5]);
            w_dec.illegal   = !((w_f7 == 7'h00) ||
                                (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
         end
         OP_I: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
               w_fmt          = IMM_SH;
               w_dec.alu_ctrl = alu_op_f3(w_f3, w_f7[5]);
               w_dec.illegal  = (w_f3 == 3'b001) ? (w_f7 != 7'h00)
                                                 : (w_f7 != 7'h00 && w_f7 != 7'h20);
            end else begin
               // addi has no sub form: funct7 bits are immediate here
               w_fmt          = IMM_I;
               w_dec.alu_ctrl = alu_op_f3(w_f3, 1'b0);
            end
         end
         OP_LOAD: begin
            w_fmt           = IMM_I;
            w_dec.reg_write = 1'b1;
            w_dec.mem_read  = 1'b1;
            w_dec.alu_src   = 1'b1;
         end
         OP_STORE: begin
            w_fmt           = IMM_S;
            w_dec.mem_write = 1'b1;
            w_dec.alu_src   = 1'b1;
         end
         OP_BRANCH: begin
            w_fmt        = IMM_B;
            w_dec.branch = 1'b1;
            case (w_f3[2:1])
               2'b00:   w_dec.alu_ctrl = ALU_SUB;
               2'b10:   w_dec.alu_ctrl = ALU_SLT;
               2'b11:   w_dec.alu_ctrl = ALU_SLTU;
               default: w_dec.illegal  = 1'b1;
            endcase
         end
         OP_LUI: begin
            w_fmt           = IMM_U;
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.rs1       = 5'd0;
         end
         OP_AUIPC: begin
            w_fmt           = IMM_U;
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 1'b1;
         end
         OP_JAL, OP_JALR: begin
            w_fmt           = (w_opcode == OP_JAL) ? IMM_J : IMM_I;
            w_dec.reg_write = 1'b1;
            w_dec.jump      = 1'b1;
            w_dec.alu_src   = 1'b1;
         end
         default: w_dec.illegal = 1'b1;
      endcase
      if (w_dec.illegal) begin
         w_dec.alu_ctrl  = ALU_ADD;
         w_dec.reg_write = 1'b0;
         w_dec.mem_read  = 1'b0;
         w_dec.mem_write = 1'b0;
         w_dec.branch    = 1'b0;
         w_dec.jump      = 1'b0;
      end
      case (w_fmt)
         IMM_I:   w_dec.imm = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S:   w_dec.imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B:   w_dec.imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                               i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U:   w_dec.imm = {i_instr[31:12], 12'b0};
         IMM_J:   w_dec.imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                               i_instr[20], i_instr[30:21], 1'b0};
         IMM_SH:  w_dec.imm = {27'b0, i_instr[24:20]};
         default: w_dec.imm = 32'd0;
      endcase
   end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered decode stage: decoder on the input, main + skid buffer of decoded bundles.
// in_ready is the inverted skid-valid register, so it never depends on out_ready combinationally.
module rv32i_decode_stage
   import rv32i_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_flush,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [31:0] i_in_instr,
   input  logic [31:0] i_in_pc,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_out_pc,
   output logic [3:0]  o_out_alu_ctrl,
   output logic        o_out_alu_src,
   output logic [31:0] o_out_imm,
   output logic [4:0]  o_out_rs1,
   output logic [4:0]  o_out_rs2,
   output logic [4:0]  o_out_rd,
   output logic [2:0]  o_out_funct3,
   output logic        o_out_reg_write,
   output logic        o_out_mem_read,
   output logic        o_out_mem_write,
   output logic        o_out_branch,
   output logic        o_out_jump,
   output logic        o_out_illegal
);

   logic [DEC_W-1:0] w_in_dec;
   entry_t           w_in_entry;
   entry_t           r_main;
   entry_t           r_skid;
   logic             r_main_vld;
   logic             r_skid_vld;
   logic             w_in_fire;
   logic             w_main_free;

   rv32i_decoder u_decoder (
      .i_instr (i_in_instr),
      .o_dec   (w_in_dec)
   );

   assign w_in_entry  = '{pc: i_in_pc, dec: dec_t'(w_in_dec)};
   assign o_in_ready  = !r_skid_vld;
   assign w_in_fire   = i_in_valid && !r_skid_vld;
   assign w_main_free = !r_main_vld || i_out_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_main     <= '0;
         r_skid     <= '0;
         r_main_vld <= 1'b0;
         r_skid_vld <= 1'b0;
      end else if (i_flush) begin
         r_main_vld <= 1'b0;
         r_skid_vld <= 1'b0;
      end else if (w_main_free) begin
         // skid is only ever full while in_ready is low, so it and a new beat never compete
         if (r_skid_vld) begin
            r_main     <= r_skid;
            r_main_vld <= 1'b1;
            r_skid_vld <= 1'b0;
         end else if (w_in_fire) begin
            r_main     <= w_in_entry;
            r_main_vld <= 1'b1;
         end else begin
            r_main_vld <= 1'b0;
         end
      end else if (w_in_fire) begin
         r_skid     <= w_in_entry;
         r_skid_vld <= 1'b1;
      end
   end

   assign o_out_valid     = r_main_vld;
   assign o_out_pc        = r_main.pc;
   assign o_out_alu_ctrl  = r_main.dec.alu_ctrl;
   assign o_out_alu_src   = r_main.dec.alu_src;
   assign o_out_imm       = r_main.dec.imm;
   assign o_out_rs1       = r_main.dec.rs1;
   assign o_out_rs2       = r_main.dec.rs2;
   assign o_out_rd        = r_main.dec.rd;
   assign o_out_funct3    = r_main.dec.funct3;
   assign o_out_reg_write = r_main.dec.reg_write;
   assign o_out_mem_read  = r_main.dec.mem_read;
   assign o_out_mem_write = r_main.dec.mem_write;
   assign o_out_branch    = r_main.dec.branch;
   assign o_out_jump      = r_main.dec.jump;
   assign o_out_illegal   = r_main.dec.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: in-order queue model plus arithmetic decode reference,
// directed pins of the model, then randomized handshake/flush/reset traffic.
module tb_rv32i_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;
   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_imm;
   logic [3:0]  out_alu_ctrl;
   logic        out_alu_src, out_reg_write, out_mem_read, out_mem_write;
   logic        out_branch, out_jump, out_illegal;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [2:0]  out_funct3;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } beat_t;

   typedef struct {
      int alu;
      bit src;
      logic [31:0] imm;
      int rs1, rs2, rd, f3;
      bit rw, mr, mw, br, jp, ill;
   } exp_t;

   beat_t       q[$];
   logic [31:0] outlog[$];

   always #5 clk = ~clk;

   rv32i_decode_stage dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_instr(in_instr), .i_in_pc(in_pc),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_pc(out_pc), .o_out_alu_ctrl(out_alu_ctrl), .o_out_alu_src(out_alu_src),
      .o_out_imm(out_imm), .o_out_rs1(out_rs1), .o_out_rs2(out_rs2), .o_out_rd(out_rd),
      .o_out_funct3(out_funct3), .o_out_reg_write(out_reg_write),
      .o_out_mem_read(out_mem_read), .o_out_mem_write(out_mem_write),
      .o_out_branch(out_branch), .o_out_jump(out_jump), .o_out_illegal(out_illegal)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sx(input int v, input int bits);
      return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
   endfunction

   // Reference decode from the ISA rules, written with lookup and arithmetic
   function automatic exp_t model(input logic [31:0] ins);
      exp_t e;
      int   base[8];
      int   f3, f7;
      bit   shift;
      base = '{0, 2, 3, 4, 5, 6, 8, 9};
      f3 = int'(ins[14:12]);
      f7 = int'(ins[31:25]);
      e = '{alu: 0, src: 0, imm: 0, rs1: int'(ins[19:15]), rs2: int'(ins[24:20]),
            rd: int'(ins[11:7]), f3: f3, rw: 0, mr: 0, mw: 0, br: 0, jp: 0, ill: 0};
      case (ins[6:0])
         7'h33: begin
            e.rw  = 1;
            e.alu = base[f3] + ((f7 == 32) ? 1 : 0);
            e.ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
         end
         7'h13: begin
            shift = (f3 == 1 || f3 == 5);
            e.rw  = 1; e.src = 1;
            e.alu = base[f3] + ((f3 == 5 && f7 == 32) ? 1 : 0);
            e.imm = shift ? int'(ins[24:20]) : sx(int'(ins[31:20]), 12);
            e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
         end
         7'h03: begin e.rw = 1; e.mr = 1; e.src = 1; e.imm = sx(int'(ins[31:20]), 12); end
         7'h23: begin
            e.mw = 1; e.src = 1;
            e.imm = sx(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12);
         end
         7'h63: begin
            e.br  = 1;
            e.imm = sx(int'(ins[31]) * 4096 + int'(ins[7]) * 2048 +
                       int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2, 13);
            if (f3 <= 1) e.alu = 1;
            else if (f3 <= 3) e.ill = 1;
            else if (f3 <= 5) e.alu = 3;
            else e.alu = 4;
         end
         7'h37: begin e.rw = 1; e.src = 1; e.imm = ins & 32'hFFFFF000; e.rs1 = 0; end
         7'h17: begin e.rw = 1; e.src = 1; e.imm = ins & 32'hFFFFF000; end
         7'h6F: begin
            e.rw = 1; e.jp = 1; e.src = 1;
            e.imm = sx(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 +
                       int'(ins[20]) * 2048 + int'(ins[30:21]) * 2, 21);
         end
         7'h67: begin e.rw = 1; e.jp = 1; e.src = 1; e.imm = sx(int'(ins[31:20]), 12); end
         default: e.ill = 1;
      endcase
      if (e.ill) begin
         e.alu = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0;
      end
      return e;
   endfunction

   // Model state advances on each edge from the same handshake rules the stage obeys
   always @(posedge clk) begin
      int n;
      n = q.size();
      if (rst_n && !flush && out_valid && out_ready) outlog.push_back(out_pc);
      if (!rst_n || flush) begin
         q.delete();
      end else begin
         if (out_ready && n > 0) void'(q.pop_front());
         if (in_valid && n < 2) q.push_back('{pc: in_pc, instr: in_instr});
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
         chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
         if (q.size() != 0 && out_valid) begin
            e = model(q[0].instr);
            chk("pc", out_pc, q[0].pc);
            chk("alu_ctrl", {28'd0, out_alu_ctrl}, e.alu);
            chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
            chk("reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
            chk("mem_read", {31'd0, out_mem_read}, {31'd0, e.mr});
            chk("mem_write", {31'd0, out_mem_write}, {31'd0, e.mw});
            chk("branch", {31'd0, out_branch}, {31'd0, e.br});
            chk("jump", {31'd0, out_jump}, {31'd0, e.jp});
            if (!e.ill) begin
               chk("alu_src", {31'd0, out_alu_src}, {31'd0, e.src});
               chk("imm", out_imm, e.imm);
               chk("rs1", {27'd0, out_rs1}, e.rs1);
               chk("rs2", {27'd0, out_rs2}, e.rs2);
               chk("rd", {27'd0, out_rd}, e.rd);
               chk("funct3", {29'd0, out_funct3}, e.f3);
            end
         end
      end
   end

   // Presents one beat from a negedge and returns at the negedge after it is taken
   task automatic offer(input logic [31:0] p, input logic [31:0] ins);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1; in_pc = p; in_instr = ins;
      for (int n = 0; n < 40; n++) begin
         acc = in_ready;
         @(negedge clk);
         if (acc) break;
      end
      chk("offer_accept", {31'd0, acc}, 32'd1);
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      int k;
      ins = $urandom;
      k = $urandom_range(0, 9);
      case (k)
         0: ins[6:0] = 7'h33;  1: ins[6:0] = 7'h13;  2: ins[6:0] = 7'h03;
         3: ins[6:0] = 7'h23;  4: ins[6:0] = 7'h63;  5: ins[6:0] = 7'h37;
         6: ins[6:0] = 7'h17;  7: ins[6:0] = 7'h6F;  8: ins[6:0] = 7'h67;
         default: ;
      endcase
      k = $urandom_range(0, 3);
      if (k == 0) ins[31:25] = 7'h00;
      else if (k == 1) ins[31:25] = 7'h20;
      return ins;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_instr = 32'd0; in_pc = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_reg_write", {31'd0, out_reg_write}, 32'd0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      offer(32'h100, 32'h002081B3);
      chk("add_valid", {31'd0, out_valid}, 32'd1);
      chk("add_alu", {28'd0, out_alu_ctrl}, 32'd0);
      chk("add_rs1", {27'd0, out_rs1}, 32'd1);
      chk("add_rs2", {27'd0, out_rs2}, 32'd2);
      chk("add_rd", {27'd0, out_rd}, 32'd3);
      chk("add_rw", {31'd0, out_reg_write}, 32'd1);
      chk("add_src", {31'd0, out_alu_src}, 32'd0);
      offer(32'h104, 32'h407302B3);
      chk("sub_alu", {28'd0, out_alu_ctrl}, 32'd1);
      offer(32'h108, 32'hFFF00093);
      chk("addi_alu", {28'd0, out_alu_ctrl}, 32'd0);
      chk("addi_src", {31'd0, out_alu_src}, 32'd1);
      chk("addi_imm", out_imm, 32'hFFFFFFFF);
      offer(32'h10C, 32'h4020D093);
      chk("srai_alu", {28'd0, out_alu_ctrl}, 32'd7);
      chk("srai_imm", out_imm, 32'd2);
      offer(32'h110, 32'h0020E463);
      chk("bltu_alu", {28'd0, out_alu_ctrl}, 32'd4);
      chk("bltu_branch", {31'd0, out_branch}, 32'd1);
      chk("bltu_imm", out_imm, 32'd8);
      chk("bltu_rw", {31'd0, out_reg_write}, 32'd0);
      offer(32'h114, 32'hFE20AE23);
      chk("sw_imm", out_imm, 32'hFFFFFFFC);
      chk("sw_mw", {31'd0, out_mem_write}, 32'd1);
      offer(32'h118, 32'hFFFFFFFF);
      chk("ill_flag", {31'd0, out_illegal}, 32'd1);
      chk("ill_flags", {27'd0, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump}, 32'd0);
      chk("ill_alu", {28'd0, out_alu_ctrl}, 32'd0);
      @(negedge clk);

      outlog.delete();
      out_ready = 1'b0;
      offer(32'h200, 32'h002081B3);
      offer(32'h204, 32'h407302B3);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1; in_pc = 32'h208; in_instr = 32'hFFF00093;
      @(negedge clk);
      chk("stall_in_ready_hold", {31'd0, in_ready}, 32'd0);
      chk("stall_hold_pc", out_pc, 32'h200);
      out_ready = 1'b1;
      offer(32'h208, 32'hFFF00093);
      repeat (3) @(negedge clk);
      chk("stall_count", outlog.size(), 32'd3);
      if (outlog.size() == 3) begin
         chk("stall_order0", outlog[0], 32'h200);
         chk("stall_order1", outlog[1], 32'h204);
         chk("stall_order2", outlog[2], 32'h208);
      end

      outlog.delete();
      out_ready = 1'b0;
      offer(32'h300, 32'h002081B3);
      offer(32'h304, 32'h0020E463);
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h308; in_instr = 32'h407302B3;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("flush_no_stale", outlog.size(), 32'd0);

      out_ready = 1'b0;
      offer(32'h400, 32'h002081B3);
      offer(32'h404, 32'hFFF00093);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst2_out_pc", out_pc, 32'd0);
      chk("rst2_out_imm", out_imm, 32'd0);
      rst_n = 1'b1; out_ready = 1'b1;
      outlog.delete();
      repeat (3) @(negedge clk);
      chk("rst2_no_stale", outlog.size(), 32'd0);

      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_instr  = rand_instr();
         in_pc     = $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         rst_n     = ($urandom_range(0, 299) != 0);
         @(negedge clk);
      end
      in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32i_decode_stage.md
# rv32i_decode_stage

Registered instruction-decode stage for the single-cycle-to-pipelined RV32I core; it is the producer side of the ALU control interface. It accepts fetched instructions over a valid/ready handshake and presents decoded fields, an immediate, and the 4-bit ALU control code to the execute stage one cycle later. A two-entry buffer (main plus skid) lets `in_ready` be purely registered while still sustaining one instruction per cycle.

## Interface
- No parameters. XLEN is fixed at 32.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous reset, active-low
- `flush`  in  1  discard all buffered instructions (branch redirect)
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage can accept; driven only from registers
- `in_instr`  in  32  instruction word
- `in_pc`  in  32  instruction address
- `out_valid`  out  1  decoded instruction valid
- `out_ready`  in  1  execute accepts
- `out_pc`  out  32  passthrough of `in_pc`
- `out_alu_ctrl`  out  4  ALU op code: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and
- `out_alu_src`  out  1  1 = operand B is `out_imm`; 0 = operand B is rs2
- `out_imm`  out  32  sign-extended immediate
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices
- `out_funct3`  out  3  passthrough, used for branch condition and load/store size
- `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_branch`, `out_jump`  out  1 each  control flags
- `out_illegal`  out  1  unsupported or malformed encoding

## Operation
Supported opcodes and their decoding:
- R-type 0x33
  - funct7 must be 0x00, or 0x20 only with funct3 000 (sub) or 101 (sra).
  - funct3 map: 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
- I-ALU 0x13
  - Same funct3 map.
  - slli/srli require funct7 0x00; srai requires funct7 0x20.
  - addi is never decoded as sub.
- LOAD 0x03 and STORE 0x23: `out_alu_ctrl` = add.
- BRANCH 0x63
  - beq/bne use sub.
  - blt/bge use slt.
  - bltu/bgeu use sltu.
  - funct3 010 and 011 are illegal.
- LUI 0x37: add, with `out_rs1` forced to 0.
- AUIPC 0x17, JAL 0x6F, JALR 0x67: add.

Immediate formats (all sign-extended from bit 31):
- I-format: LOAD, I-ALU, JALR.
- S-format: STORE.
- B-format: BRANCH.
- U-format: LUI, AUIPC.
- J-format: JAL.
- For shift-immediates, `out_imm` = {27'b0, instr[24:20]}.
- R-type: `out_imm` = 0.

Illegal encodings (any other opcode or malformed funct field):
- `out_illegal`=1.
- `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_branch`, `out_jump` all 0.
- `out_alu_ctrl`=0.
- The beat still flows through the handshake normally.

Writes to rd = 0 still assert `out_reg_write`; the register file ignores them.

## Timing
Reset (`rst_n` low at a clock edge):
- Both buffer entries are invalid and `out_valid`=0.
- `in_ready`=1 from the first edge after reset.
- All data outputs are 0.
- Reset mid-stall drops all buffered beats.

Handshakes:
- An input beat transfers on an edge with `in_valid` & `in_ready`.
- An output beat transfers on an edge with `out_valid` & `out_ready`.
- Latency: a beat accepted into an empty stage appears on the output at the next edge.
- Throughput: 1 beat/cycle while `out_ready`=1.

Stall:
- With `out_valid`=1 and `out_ready`=0, an accepted beat goes to the skid entry.
- `in_ready` goes to 0 the following cycle.
- When the main entry drains, the skid entry moves to main and `in_ready` returns to 1 the next cycle.
- Order is strictly preserved; no beat is lost or duplicated.

Simultaneous accept and drain: the new beat enters main directly and the skid entry stays empty.

Flush:
- At the edge where `flush`=1, both entries are invalidated.
- Any input beat handshaken in that same cycle is discarded.
- Next cycle: `out_valid`=0 and `in_ready`=1.
- `flush` takes priority over every other event.
- Output outputs remain stable while `out_valid` & !`out_ready`.

## Structure
- `rv32i_pkg` holds:
  - opcode constants;
  - ALU control codes 0–9, shared with the ALU;
  - the immediate-format enum.
- Sub-module `rv32i_decoder`: purely combinational, decoding one instruction word into the field bundle.
  - One instance sits on the input side, so both buffer entries hold decoded bundles.
  - The top level contains only the two-entry buffer and its control logic.

## Test plan
- add x3,x1,x2 (0x002081B3) into an empty stage with `out_ready`=1 -> next cycle: `out_valid`=1, alu_ctrl=0, rs1=1, rs2=2, rd=3, reg_write=1, alu_src=0.
- sub x5,x6,x7 (0x407302B3) -> alu_ctrl=1. addi x1,x0,-1 (0xFFF00093) -> alu_ctrl=0, alu_src=1, imm=0xFFFFFFFF. srai (0x4020D093) -> alu_ctrl=7, imm=2.
- bltu (0x0020E463) -> alu_ctrl=4, branch=1, imm=8, reg_write=0.
- Hold `out_ready`=0 and offer 3 beats back to back:
  - beats 1 and 2 are accepted;
  - `in_ready`=0 from cycle 3;
  - then release `out_ready` -> outputs 1,2,3 in order, each exactly once.
- 0xFFFFFFFF -> illegal=1, all write/mem flags 0.
- Assert `flush` with both entries full -> next cycle `out_valid`=0, `in_ready`=1, and no stale beat ever appears.
